// File: rtl/sharpe_pkg.sv
// sharpe_pkg: shared types and constants for the Sharpe-ratio selector.
//   sel_state_e : selector FSM states (idle / hold current best / challenge in progress).
//   DIR_*       : encodings of the out_dir compare result.
package sharpe_pkg;

  typedef enum logic [1:0] {
    StIdle      = 2'd0,
    StHold      = 2'd1,
    StChallenge = 2'd2
  } sel_state_e;

  localparam logic [1:0] DIR_EQ    = 2'b00;
  localparam logic [1:0] DIR_UP    = 2'b01;
  localparam logic [1:0] DIR_DN    = 2'b10;
  localparam logic [1:0] DIR_FIRST = 2'b11;

endpackage

// File: rtl/sharpe_cmp.sv
// sharpe_cmp: combinational compare of a new Sharpe sample.
//   i_new     : new sample value
//   i_old     : previous value stored for the same channel
//   i_old_vld : i_old is meaningful (channel has been seen before)
//   i_best    : current best value (before this update)
//   o_dir     : new-vs-old result (DIR_EQ / DIR_UP / DIR_DN / DIR_FIRST)
//   o_qual    : i_new >= i_best + HYST, evaluated without wrap
module sharpe_cmp
  import sharpe_pkg::*;
#(
  parameter int unsigned W    = 8,
  parameter int unsigned HYST = 2
) (
  input  logic [W-1:0] i_new,
  input  logic [W-1:0] i_old,
  input  logic         i_old_vld,
  input  logic [W-1:0] i_best,
  output logic [1:0]   o_dir,
  output logic         o_qual
);

  logic [W:0] w_thr;

  // One extra bit keeps the margin add from wrapping; a threshold above 2^W-1
  // can never be met by a W-bit sample, so saturation needs no special case.
  assign w_thr  = {1'b0, i_best} + (W + 1)'(HYST);
  assign o_qual = ({1'b0, i_new} >= w_thr);

  always_comb begin
    o_dir = DIR_EQ;
    if (!i_old_vld) begin
      o_dir = DIR_FIRST;
    end else if (i_new > i_old) begin
      o_dir = DIR_UP;
    end else if (i_new < i_old) begin
      o_dir = DIR_DN;
    end
  end

endmodule

// File: rtl/sharpe_selector.sv
// sharpe_selector: multi-channel Sharpe-ratio comparator and best-strategy selector.
// Compile-time option: SHARPE_HYST_EN enables the HYST margin and CONFIRM count;
// without it the effective margin is 1 and any strictly greater sample switches at once.
// Ports:
//   clk, rst                        : clock, synchronous active-high reset
//   in_valid/in_ready/in_ch/in_sharpe : sample input handshake
//   out_valid/out_ready/out_ch/out_sharpe/out_dir : per-sample compare result
//   best_ch/best_sharpe/best_vld    : current best channel and its value
//   switch_pulse                    : one cycle high when best_ch is loaded or changes
module sharpe_selector
  import sharpe_pkg::*;
#(
  parameter int unsigned W       = 8,
  parameter int unsigned N       = 4,
  parameter int unsigned HYST    = 2,
  parameter int unsigned CONFIRM = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [$clog2(N)-1:0] in_ch,
  input  logic [W-1:0]         in_sharpe,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [$clog2(N)-1:0] out_ch,
  output logic [W-1:0]         out_sharpe,
  output logic [1:0]           out_dir,
  output logic [$clog2(N)-1:0] best_ch,
  output logic [W-1:0]         best_sharpe,
  output logic                 best_vld,
  output logic                 switch_pulse
);

  localparam int unsigned CW = $clog2(N);
  localparam bit ParamsOk = (N >= 2) && (CONFIRM >= 1) && (HYST < (1 << W));

  if (!ParamsOk) begin : g_param_check
    $error("sharpe_selector: invalid parameters");
  end

`ifdef SHARPE_HYST_EN
  localparam int unsigned HystEff = HYST;
  localparam int unsigned ConfEff = CONFIRM;
  localparam int unsigned CntW    = $clog2(ConfEff + 1);
`else
  localparam int unsigned HystEff = 1;
`endif

  // Handshake and channel decode
  logic w_acc, w_ch_ok, w_upd;

  assign in_ready = !out_valid || out_ready;
  assign w_acc    = in_valid && in_ready;
  assign w_ch_ok  = (32'(in_ch) < N);
  // Out-of-range channels are consumed but otherwise ignored.
  assign w_upd    = w_acc && w_ch_ok;

  // Per-channel table; valid bits gate the (unreset) values.
  logic [W-1:0] r_tab_val [N];
  logic [N-1:0] r_tab_vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tab_vld <= '0;
    end else if (w_upd) begin
      r_tab_val[in_ch] <= in_sharpe;
      r_tab_vld[in_ch] <= 1'b1;
    end
  end

  logic [1:0] w_dir;
  logic       w_qual;

  sharpe_cmp #(
    .W    (W),
    .HYST (HystEff)
  ) u_cmp (
    .i_new     (in_sharpe),
    .i_old     (r_tab_val[in_ch]),
    .i_old_vld (r_tab_vld[in_ch]),
    .i_best    (best_sharpe),
    .o_dir     (w_dir),
    .o_qual    (w_qual)
  );

  // Result register
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_ch     <= '0;
      out_sharpe <= '0;
      out_dir    <= DIR_EQ;
    end else if (w_upd) begin
      out_valid  <= 1'b1;
      out_ch     <= in_ch;
      out_sharpe <= in_sharpe;
      out_dir    <= w_dir;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

  // Selector FSM
  sel_state_e    r_state, w_state_d;
  logic [CW-1:0] w_best_ch_d;
  logic [W-1:0]  w_best_sharpe_d;
  logic          w_best_vld_d, w_pulse_d;
  logic          w_is_best;

  assign w_is_best = (in_ch == best_ch);

`ifdef SHARPE_HYST_EN
  logic [CW-1:0]   r_chal_ch, w_chal_ch_d;
  logic [CntW-1:0] r_cnt, w_cnt_d, w_cnt_inc;
  logic            w_is_chal, w_confirmed;

  assign w_is_chal   = (in_ch == r_chal_ch);
  assign w_cnt_inc   = r_cnt + CntW'(1);
  assign w_confirmed = (w_cnt_inc == CntW'(ConfEff));
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= StIdle;
      best_ch      <= '0;
      best_sharpe  <= '0;
      best_vld     <= 1'b0;
      switch_pulse <= 1'b0;
`ifdef SHARPE_HYST_EN
      r_chal_ch    <= '0;
      r_cnt        <= '0;
`endif
    end else begin
      r_state      <= w_state_d;
      best_ch      <= w_best_ch_d;
      best_sharpe  <= w_best_sharpe_d;
      best_vld     <= w_best_vld_d;
      switch_pulse <= w_pulse_d;
`ifdef SHARPE_HYST_EN
      r_chal_ch    <= w_chal_ch_d;
      r_cnt        <= w_cnt_d;
`endif
    end
  end

  always_comb begin
    w_state_d = r_state;
    if (w_upd) begin
      unique case (r_state)
        StIdle: w_state_d = StHold;
`ifdef SHARPE_HYST_EN
        StHold: begin
          if (!w_is_best && w_qual && (ConfEff > 1)) w_state_d = StChallenge;
        end
        StChallenge: begin
          if (!w_is_best && w_is_chal && (!w_qual || w_confirmed)) w_state_d = StHold;
        end
`else
        StHold: w_state_d = StHold;
`endif
        default: w_state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    w_best_ch_d     = best_ch;
    w_best_sharpe_d = best_sharpe;
    w_best_vld_d    = best_vld;
    w_pulse_d       = 1'b0;
`ifdef SHARPE_HYST_EN
    w_chal_ch_d     = r_chal_ch;
    w_cnt_d         = r_cnt;
`endif
    if (w_upd) begin
      unique case (r_state)
        StIdle: begin
          w_best_ch_d     = in_ch;
          w_best_sharpe_d = in_sharpe;
          w_best_vld_d    = 1'b1;
          w_pulse_d       = 1'b1;
        end
        StHold: begin
          if (w_is_best) begin
            w_best_sharpe_d = in_sharpe;
          end else if (w_qual) begin
`ifdef SHARPE_HYST_EN
            if (ConfEff == 1) begin
              w_best_ch_d     = in_ch;
              w_best_sharpe_d = in_sharpe;
              w_pulse_d       = 1'b1;
            end else begin
              w_chal_ch_d = in_ch;
              w_cnt_d     = CntW'(1);
            end
`else
            w_best_ch_d     = in_ch;
            w_best_sharpe_d = in_sharpe;
            w_pulse_d       = 1'b1;
`endif
          end
        end
`ifdef SHARPE_HYST_EN
        StChallenge: begin
          if (w_is_best) begin
            w_best_sharpe_d = in_sharpe;
          end else if (w_is_chal) begin
            if (!w_qual) begin
              w_cnt_d = '0;
            end else if (w_confirmed) begin
              w_best_ch_d     = in_ch;
              w_best_sharpe_d = in_sharpe;
              w_pulse_d       = 1'b1;
              w_cnt_d         = '0;
            end else begin
              w_cnt_d = w_cnt_inc;
            end
          end else if (w_qual) begin
            // A stronger third channel takes over the challenge from scratch.
            w_chal_ch_d = in_ch;
            w_cnt_d     = CntW'(1);
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sharpe_selector.sv
// tb_sharpe_selector: directed self-checking bench for sharpe_selector
// (N=4, W=8, HYST=2, CONFIRM=3). Expectations follow SHARPE_HYST_EN when defined.
module tb_sharpe_selector;

`ifdef SHARPE_HYST_EN
  localparam bit HystEn = 1'b1;
`else
  localparam bit HystEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] in_ch = '0;
  logic [7:0] in_sharpe = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [1:0] out_ch;
  logic [7:0] out_sharpe;
  logic [1:0] out_dir;
  logic [1:0] best_ch;
  logic [7:0] best_sharpe;
  logic       best_vld;
  logic       switch_pulse;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sharpe_selector #(
    .W       (8),
    .N       (4),
    .HYST    (2),
    .CONFIRM (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_ch        (in_ch),
    .in_sharpe    (in_sharpe),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_ch       (out_ch),
    .out_sharpe   (out_sharpe),
    .out_dir      (out_dir),
    .best_ch      (best_ch),
    .best_sharpe  (best_sharpe),
    .best_vld     (best_vld),
    .switch_pulse (switch_pulse)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drive one sample; returns at the negedge after the accepting edge.
  task automatic send(input int ch, input int v);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("send_timeout", 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    in_ch     = 2'(ch);
    in_sharpe = 8'(v);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_dir", 32'(out_dir), 0);
    check("rst_best_ch", 32'(best_ch), 0);
    check("rst_best_sharpe", 32'(best_sharpe), 0);
    check("rst_best_vld", 32'(best_vld), 0);
    check("rst_pulse", 32'(switch_pulse), 0);

    // First sample loads best
    send(0, 50);
    check("first_valid", 32'(out_valid), 1);
    check("first_dir", 32'(out_dir), 3);
    check("first_out_sharpe", 32'(out_sharpe), 50);
    check("first_best_ch", 32'(best_ch), 0);
    check("first_best_sharpe", 32'(best_sharpe), 50);
    check("first_best_vld", 32'(best_vld), 1);
    check("first_pulse", 32'(switch_pulse), 1);
    @(negedge clk);
    check("first_pulse_end", 32'(switch_pulse), 0);
    check("first_valid_drain", 32'(out_valid), 0);

    // Equal then down on the best channel
    send(0, 50);
    check("eq_dir", 32'(out_dir), 0);
    send(0, 40);
    check("dn_dir", 32'(out_dir), 2);
    check("dn_best_sharpe", 32'(best_sharpe), 40);
    check("dn_pulse", 32'(switch_pulse), 0);
    send(0, 45);
    check("up_dir", 32'(out_dir), 1);

    // Margin boundary: 51 over 50
    do_reset();
    send(0, 50);
    send(1, 51);
    check("m51_best_ch", 32'(best_ch), HystEn ? 0 : 1);

    // Confirmed switch on 52
    do_reset();
    send(0, 50);
    for (int k = 1; k <= 3; k++) begin
      send(1, 52);
      check($sformatf("conf_best_ch_%0d", k), 32'(best_ch), HystEn ? (k == 3 ? 1 : 0) : 1);
      check($sformatf("conf_pulse_%0d", k), 32'(switch_pulse),
            HystEn ? (k == 3 ? 1 : 0) : (k == 1 ? 1 : 0));
    end
    check("conf_best_sharpe", 32'(best_sharpe), 52);

    // Interrupted challenge, then restart from cnt=1
    do_reset();
    send(0, 50);
    begin
      int vals [6] = '{60, 60, 51, 60, 60, 60};
      for (int k = 0; k < 6; k++) begin
        send(1, vals[k]);
        check($sformatf("intr_best_ch_%0d", k), 32'(best_ch), HystEn ? (k == 5 ? 1 : 0) : 1);
      end
    end
    check("intr_best_sharpe", 32'(best_sharpe), 60);

    // Backpressure
    do_reset();
    out_ready = 1'b0;
    send(2, 70);
    check("bp_valid", 32'(out_valid), 1);
    check("bp_in_ready", 32'(in_ready), 0);
    check("bp_pulse", 32'(switch_pulse), 1);
    check("bp_best_ch", 32'(best_ch), 2);
    in_valid  = 1'b1;
    in_ch     = 2'd3;
    in_sharpe = 8'd80;
    repeat (3) @(negedge clk);
    check("bp_hold_ready", 32'(in_ready), 0);
    check("bp_hold_valid", 32'(out_valid), 1);
    check("bp_hold_ch", 32'(out_ch), 2);
    check("bp_hold_sharpe", 32'(out_sharpe), 70);
    check("bp_hold_dir", 32'(out_dir), 3);
    check("bp_hold_pulse", 32'(switch_pulse), 0);
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_rel_valid", 32'(out_valid), 1);
    check("bp_rel_ch", 32'(out_ch), 3);
    check("bp_rel_sharpe", 32'(out_sharpe), 80);
    check("bp_rel_best_ch", 32'(best_ch), HystEn ? 2 : 3);

    // Saturation: best 254, challenger 255
    do_reset();
    send(0, 254);
    for (int k = 0; k < 5; k++) send(2, 255);
    check("sat_best_ch", 32'(best_ch), HystEn ? 0 : 2);
    check("sat_best_sharpe", 32'(best_sharpe), HystEn ? 254 : 255);

    // Reset mid-challenge
    do_reset();
    send(0, 50);
    send(1, 60);
    send(1, 60);
    do_reset();
    check("mid_rst_valid", 32'(out_valid), 0);
    check("mid_rst_in_ready", 32'(in_ready), 1);
    check("mid_rst_out_sharpe", 32'(out_sharpe), 0);
    check("mid_rst_best_ch", 32'(best_ch), 0);
    check("mid_rst_best_sharpe", 32'(best_sharpe), 0);
    check("mid_rst_best_vld", 32'(best_vld), 0);
    send(3, 40);
    check("post_rst_dir", 32'(out_dir), 3);
    check("post_rst_best_ch", 32'(best_ch), 3);
    check("post_rst_pulse", 32'(switch_pulse), 1);
    send(1, 60);
    check("post_rst_tab_clr", 32'(out_dir), 3);
    check("post_rst_ch1_best", 32'(best_ch), HystEn ? 3 : 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
